// File: rtl/adder_tree_reduce_ctrl.sv
// adder_tree_reduce_ctrl
// Reduces signed vectors that arrive as beats of LENGTH elements. Each beat passes through
// a pipelined adder tree with one register per layer. The per-beat sums are accumulated into
// one ACC_WIDTH result per vector. Results leave through a 2-entry first-word-fall-through
// FIFO. Input acceptance is credit based, so a result never reaches a full FIFO.
module adder_tree_reduce_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int LENGTH     = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int BEAT_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LENGTH*DATA_WIDTH-1:0] in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_WIDTH-1:0]         out_sum,
   output logic                         out_ovf,
   output logic [BEAT_W-1:0]            out_beats,
   output logic                         busy
);

   localparam int L  = $clog2(LENGTH);
   // Tree node width: enough headroom that a full beat sum cannot overflow.
   localparam int TW = DATA_WIDTH + L;

   typedef enum logic {
      ACC_IDLE = 1'b0,
      ACC_RUN  = 1'b1
   } acc_state_t;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   logic                        r_rst_done;
   logic [L-1:0]                r_tag_vld;
   logic [L-1:0]                r_tag_last;
   logic [7:0]                  w_inflight_last;
   logic                        w_tag_any_next;
   logic                        w_accept;
   logic                        w_tag_out_vld;
   logic                        w_tag_out_last;
   logic signed [TW-1:0]        w_tree_out;
   logic signed [ACC_WIDTH-1:0] w_tree_ext;

   acc_state_t                  r_state;
   acc_state_t                  w_state_next;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic signed [ACC_WIDTH-1:0] w_acc_next;
   logic signed [ACC_WIDTH-1:0] w_sum;
   logic                        r_ovf;
   logic                        w_ovf_next;
   logic                        w_add_ovf;
   logic [BEAT_W-1:0]           r_cnt;
   logic [BEAT_W-1:0]           w_cnt_next;
   logic [BEAT_W-1:0]           w_cnt_inc;
   logic                        w_push;

   logic [ACC_WIDTH-1:0]        r_mem_sum   [2];
   logic                        r_mem_ovf   [2];
   logic [BEAT_W-1:0]           r_mem_beats [2];
   logic                        r_wr_ptr;
   logic                        r_rd_ptr;
   logic [1:0]                  r_count;
   logic [1:0]                  w_count_next;
   logic                        w_pop;
   logic                        w_head_sel;
   logic                        r_busy;

   // A beat is only taken when a result slot is guaranteed for every last beat in flight.
   assign in_ready = r_rst_done && ((9'(w_inflight_last) + 9'(r_count)) < 9'd2);
   assign w_accept = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Adder tree: layer gl holds LENGTH>>(gl+1) registered pairwise sums
   // ------------------------------------------------------------------
   genvar gl, gi;
   generate
      for (gl = 0; gl < L; gl++) begin : g_layer
         localparam int N = LENGTH >> (gl + 1);
         for (gi = 0; gi < N; gi++) begin : g_node
            logic signed [TW-1:0] w_a;
            logic signed [TW-1:0] w_b;
            logic signed [TW-1:0] r_node;
            if (gl == 0) begin : g_leaf
               logic signed [DATA_WIDTH-1:0] w_ea;
               logic signed [DATA_WIDTH-1:0] w_eb;
               assign w_ea = in_data[(2*gi)*DATA_WIDTH +: DATA_WIDTH];
               assign w_eb = in_data[(2*gi+1)*DATA_WIDTH +: DATA_WIDTH];
               assign w_a  = TW'(w_ea);
               assign w_b  = TW'(w_eb);
            end else begin : g_inner
               assign w_a = g_layer[gl-1].g_node[2*gi].r_node;
               assign w_b = g_layer[gl-1].g_node[2*gi+1].r_node;
            end
            // Free-running layer register; validity is carried by the tag pipe.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) r_node <= '0;
               else        r_node <= w_a + w_b;
            end
         end
      end
   endgenerate

   assign w_tree_out     = g_layer[L-1].g_node[0].r_node;
   assign w_tree_ext     = ACC_WIDTH'(w_tree_out);
   assign w_tag_out_vld  = r_tag_vld[L-1];
   assign w_tag_out_last = r_tag_last[L-1];

   // Tag pipe {vld,last} shifts in lockstep with the tree layers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_vld  <= '0;
         r_tag_last <= '0;
      end else begin
         r_tag_vld[0]  <= w_accept;
         r_tag_last[0] <= w_accept && in_last;
         for (int i = 1; i < L; i++) begin
            r_tag_vld[i]  <= r_tag_vld[i-1];
            r_tag_last[i] <= r_tag_last[i-1];
         end
      end
   end

   // Count last beats in flight; also form the next-cycle "any tag valid" for busy.
   always_comb begin
      w_inflight_last = '0;
      w_tag_any_next  = w_accept;
      for (int i = 0; i < L; i++) begin
         w_inflight_last = w_inflight_last + 8'(r_tag_vld[i] & r_tag_last[i]);
      end
      for (int i = 0; i < L - 1; i++) begin
         w_tag_any_next = w_tag_any_next | r_tag_vld[i];
      end
   end

   // ------------------------------------------------------------------
   // Accumulator FSM
   // ------------------------------------------------------------------
   assign w_sum     = r_acc + w_tree_ext;
   assign w_add_ovf = (r_acc[ACC_WIDTH-1] == w_tree_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + BEAT_W'(1);

   // Accumulator state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACC_IDLE;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
         r_ovf   <= w_ovf_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state: a valid last output closes the vector (push, clear); otherwise keep adding.
   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_ovf_next   = r_ovf;
      w_cnt_next   = r_cnt;
      w_push       = 1'b0;
      if (w_tag_out_vld) begin
         if (w_tag_out_last) begin
            w_push       = 1'b1;
            w_state_next = ACC_IDLE;
            w_acc_next   = '0;
            w_ovf_next   = 1'b0;
            w_cnt_next   = '0;
         end else begin
            w_state_next = ACC_RUN;
            w_acc_next   = w_sum;
            w_ovf_next   = r_ovf | w_add_ovf;
            w_cnt_next   = w_cnt_inc;
         end
      end
   end

   // ------------------------------------------------------------------
   // 2-entry FWFT result FIFO
   // ------------------------------------------------------------------
   assign out_valid = (r_count != 2'd0);
   assign w_pop     = out_valid && out_ready;

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 2'd1;
         2'b01:   w_count_next = r_count - 2'd1;
         default: w_count_next = r_count;
      endcase
   end

   // FIFO storage and pointers; a push and a pop in one cycle are both honoured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem_sum[i]   <= '0;
            r_mem_ovf[i]   <= 1'b0;
            r_mem_beats[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem_sum[r_wr_ptr]   <= w_sum;
            r_mem_ovf[r_wr_ptr]   <= r_ovf | w_add_ovf;
            r_mem_beats[r_wr_ptr] <= w_cnt_inc;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= w_count_next;
      end
   end

   // When empty, the slot behind the read pointer still holds the last popped entry,
   // so the outputs keep their last value without extra registers.
   assign w_head_sel = out_valid ? r_rd_ptr : ~r_rd_ptr;
   assign out_sum    = r_mem_sum[w_head_sel];
   assign out_ovf    = r_mem_ovf[w_head_sel];
   assign out_beats  = r_mem_beats[w_head_sel];

   // Busy and ready-enable registers; busy is formed from next-state values so it is current.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= 1'b0;
         r_rst_done <= 1'b0;
      end else begin
         r_busy     <= w_tag_any_next || (w_state_next == ACC_RUN) || (w_count_next != 2'd0);
         r_rst_done <= 1'b1;
      end
   end

   assign busy = r_busy;

   // Credit accounting must keep a push from ever meeting a full FIFO.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_adder_tree_reduce_ctrl.sv
// Bench for adder_tree_reduce_ctrl (LENGTH=4, DATA_WIDTH=8, ACC_WIDTH=16).
// A monitor keeps a vector-level reference model (plain integer sums, queue of expected
// results, count of owed results) and compares every pop and every in_ready cycle.
module tb_adder_tree_reduce_ctrl;

   localparam int DW  = 8;
   localparam int LEN = 4;
   localparam int AW  = 16;
   localparam int BW  = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [LEN*DW-1:0]  in_data = '0;
   logic               in_last = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [AW-1:0]      out_sum;
   logic               out_ovf;
   logic [BW-1:0]      out_beats;
   logic               busy;

   adder_tree_reduce_ctrl #(
      .DATA_WIDTH(DW), .LENGTH(LEN), .ACC_WIDTH(AW), .BEAT_W(BW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf), .out_beats(out_beats), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] sum;
      logic          ovf;
      logic [BW-1:0] beats;
   } res_t;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   int   m_acc = 0;
   bit   m_ovf = 0;
   int   m_cnt = 0;
   int   owed = 0;
   int   live_edges = 0;
   int   cyc = 0;
   int   n_pops = 0;
   int   n_vec = 0;
   int   last_acc_cyc = 0;
   int   valid_rise_cyc = 0;
   bit   prev_valid = 0;
   bit   prev_stall = 0;
   res_t prev_out;
   res_t last_pop;
   bit   rnd_mode = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int beat_sum(input logic [LEN*DW-1:0] d);
      int s = 0;
      for (int k = 0; k < LEN; k++) s += int'($signed(d[k*DW +: DW]));
      return s;
   endfunction

   function automatic logic [LEN*DW-1:0] pk(input byte e0, input byte e1, input byte e2, input byte e3);
      return {e3, e2, e1, e0};
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst_n) live_edges++;
      else       live_edges = 0;
   end

   // Random output backpressure during the random phase.
   always @(posedge clk) begin
      if (rnd_mode) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor / reference model / compare process.
   always @(negedge clk) begin
      int   bs;
      int   nw;
      logic signed [AW-1:0] t;
      res_t r;
      if (!rst_n) begin
         exp_q.delete();
         m_acc = 0; m_ovf = 0; m_cnt = 0; owed = 0;
         prev_stall = 0; prev_valid = 0;
         check("rst_in_ready", in_ready, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_out_sum", out_sum, 0);
      end else begin
         // Ready must reflect the number of results still owed (accepted last beats not yet popped).
         if (live_edges >= 1) check("in_ready_credit", in_ready, (owed < 2) ? 1 : 0);
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_sum", out_sum, prev_out.sum);
            check("stall_ovf", out_ovf, prev_out.ovf);
            check("stall_beats", out_beats, prev_out.beats);
         end
         if (out_valid && !prev_valid) valid_rise_cyc = cyc;
         if (in_valid && in_ready) begin
            bs = beat_sum(in_data);
            nw = m_acc + bs;
            if (nw > 32767 || nw < -32768) m_ovf = 1;
            t = nw[AW-1:0];
            m_acc = int'(t);
            m_cnt++;
            if (in_last) begin
               r.sum   = t;
               r.ovf   = m_ovf;
               r.beats = (m_cnt > 255) ? 8'd255 : m_cnt[BW-1:0];
               exp_q.push_back(r);
               m_acc = 0; m_ovf = 0; m_cnt = 0;
               owed++;
               last_acc_cyc = cyc;
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               r = exp_q.pop_front();
               check("res_sum", out_sum, r.sum);
               check("res_ovf", out_ovf, r.ovf);
               check("res_beats", out_beats, r.beats);
            end
            $display("result %0d: sum=%0d ovf=%0d beats=%0d", n_pops, $signed(out_sum), out_ovf, out_beats);
            last_pop.sum = out_sum; last_pop.ovf = out_ovf; last_pop.beats = out_beats;
            n_pops++;
            owed--;
         end
         prev_valid     = out_valid;
         prev_stall     = out_valid && !out_ready;
         prev_out.sum   = out_sum;
         prev_out.ovf   = out_ovf;
         prev_out.beats = out_beats;
      end
   end

   task automatic send_beat(input logic [LEN*DW-1:0] d, input logic last);
      bit acc;
      int n;
      acc = 0; n = 0;
      in_valid = 1'b1; in_data = d; in_last = last;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 2000);
      if (!acc) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_pops(input int target);
      int n;
      n = 0;
      while (n_pops < target && n < 2000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("pop_wait", (n_pops >= target) ? 1 : 0, 1);
   endtask

   initial begin
      int base;
      int nb;
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int nb;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: idle after reset release
      repeat (3) @(negedge clk);
      check("t1_in_ready", in_ready, 1);
      check("t1_out_valid", out_valid, 0);
      check("t1_busy", busy, 0);
      @(posedge clk); #1;

      // 2: single beat {1,2,3,4}; sum 10, result 3 cycles after acceptance
      send_beat(pk(1, 2, 3, 4), 1'b1);
      wait_pops(1);
      check("t2_sum", last_pop.sum, 10);
      check("t2_beats", last_pop.beats, 1);
      check("t2_ovf", last_pop.ovf, 0);
      check("t2_latency", valid_rise_cyc - last_acc_cyc, 3);

      // 3: 4*127 + 4*(-128) + 4*1 = 508 - 512 + 4 = 0
      send_beat(pk(127, 127, 127, 127), 1'b0);
      send_beat(pk(-128, -128, -128, -128), 1'b0);
      send_beat(pk(1, 1, 1, 1), 1'b1);
      wait_pops(2);
      check("t3_sum", last_pop.sum, 0);
      check("t3_beats", last_pop.beats, 3);
      check("t3_ovf", last_pop.ovf, 0);

      // 4: 300 beats of 508 -> 152400 mod 65536 = 21328, overflow, beats saturate at 255
      for (int i = 0; i < 300; i++) begin
         send_beat(pk(127, 127, 127, 127), (i == 299) ? 1'b1 : 1'b0);
         if (i == 0) begin
            @(negedge clk);
            check("t4_busy", busy, 1);
            @(posedge clk); #1;
         end
      end
      wait_pops(3);
      check("t4_sum", last_pop.sum, 21328);
      check("t4_ovf", last_pop.ovf, 1);
      check("t4_beats", last_pop.beats, 255);

      // 5: stalled output, two results buffer and input backs up
      out_ready = 1'b0;
      send_beat(pk(10, 0, 0, 0), 1'b1);
      send_beat(pk(20, 0, 0, 0), 1'b1);
      in_valid = 1'b1; in_data = pk(30, 0, 0, 0); in_last = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("t5_in_ready_low", in_ready, 0);
      end
      check("t5_out_valid", out_valid, 1);
      check("t5_head_sum", out_sum, 10);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_beat(pk(30, 0, 0, 0), 1'b1);
      wait_pops(6);
      check("t5_last_sum", last_pop.sum, 30);

      // 6: reset in the middle of a 4-beat vector
      send_beat(pk(9, 9, 9, 9), 1'b0);
      send_beat(pk(9, 9, 9, 9), 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      base = n_pops;
      repeat (2) @(posedge clk);
      #1;
      send_beat(pk(5, 5, 5, 5), 1'b1);
      wait_pops(base + 1);
      repeat (5) @(posedge clk);
      #1;
      check("t6_pop_count", n_pops - base, 1);
      check("t6_sum", last_pop.sum, 20);
      check("t6_beats", last_pop.beats, 1);

      // Random vectors with random gaps and random backpressure
      rnd_mode = 1;
      for (int v = 0; v < 200; v++) begin
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            send_beat(LEN*DW'($urandom), (b == nb - 1) ? 1'b1 : 1'b0);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         n_vec++;
      end
      rnd_mode = 0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      base = 0;
      while (exp_q.size() != 0 && base < 2000) begin
         @(posedge clk);
         base++;
      end
      repeat (4) @(negedge clk);
      check("drain_queue_empty", exp_q.size(), 0);
      check("drain_out_valid", out_valid, 0);
      check("drain_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
